// File: rtl/sobel_mag_core_if.sv
`timescale 1ns/1ps
// Window-in / result-out handshake bundle for sobel_mag_core.
// The core connects through the slave modport, the source/sink through master.
interface sobel_mag_core_if #(
  parameter int DATA_W = 8,
  parameter int MAG_W  = DATA_W + 3,
  parameter int CNT_W  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [9*DATA_W-1:0]   A;
  logic                  mode;
  logic [MAG_W-1:0]      hi_thr;
  logic [MAG_W-1:0]      lo_thr;
  logic                  out_valid;
  logic                  out_ready;
  logic [MAG_W-1:0]      GM;
  logic [1:0]            edge_class;
  logic [7:0]            edge_pix;
  logic [CNT_W-1:0]      strong_cnt;
  logic [CNT_W-1:0]      weak_cnt;

  modport master (
    output in_valid, A, mode, hi_thr, lo_thr, out_ready,
    input  in_ready, out_valid, GM, edge_class, edge_pix, strong_cnt, weak_cnt
  );

  modport slave (
    input  in_valid, A, mode, hi_thr, lo_thr, out_ready,
    output in_ready, out_valid, GM, edge_class, edge_pix, strong_cnt, weak_cnt
  );
endinterface

// File: rtl/sobel_mag_core.sv
`timescale 1ns/1ps
// Sobel gradient-magnitude core: one 3x3 window in, L1 or exact integer L2
// magnitude out, classified against runtime thresholds, with saturating counters.
module sobel_mag_core #(
  parameter int DATA_W = 8,
  parameter int MAG_W  = DATA_W + 3,
  parameter int CNT_W  = 16
) (
  input  logic            Clock,
  input  logic            reset,
  input  logic            Enable,
  sobel_mag_core_if.slave bus
);
  localparam int G_W   = DATA_W + 3;
  localparam int A_W   = DATA_W + 2;
  localparam int S_W   = 2*DATA_W + 5;
  localparam int R_W   = 2*MAG_W;
  localparam int REM_W = MAG_W + 1;
  localparam int SH_W  = MAG_W + 3;
  localparam int IT_W  = $clog2(MAG_W);

  typedef enum logic [2:0] {
    ST_IDLE, ST_GRAD, ST_SQ, ST_ROOT, ST_CLASS, ST_OUT
  } state_t;

  state_t              r_state;
  logic [9*DATA_W-1:0] r_win;
  logic                r_mode;
  logic [MAG_W-1:0]    r_hi, r_lo;
  logic [A_W-1:0]      r_ax, r_ay;
  logic [R_W-1:0]      r_rad;
  logic [REM_W-1:0]    r_rem;
  logic [MAG_W-1:0]    r_root;
  logic [IT_W-1:0]     r_cnt;
  logic [MAG_W-1:0]    r_gm;
  logic [1:0]          r_class;
  logic [7:0]          r_pix;
  logic                r_out_valid;
  logic [CNT_W-1:0]    r_strong, r_weak;

  logic signed [G_W-1:0] w_p [9];
  logic signed [G_W-1:0] w_gx, w_gy;
  logic [A_W-1:0]        w_ax, w_ay;
  logic [S_W-1:0]        w_ax_ext, w_ay_ext, w_sq;
  logic [SH_W-1:0]       w_rem_sh, w_trial;
  logic                  w_fit;
  logic [REM_W-1:0]      w_rem_nx;
  logic [MAG_W-1:0]      w_mag;
  logic [1:0]            w_class;
  logic [7:0]            w_pix;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_pix
      assign w_p[gi] = $signed({{(G_W-DATA_W){1'b0}}, r_win[gi*DATA_W +: DATA_W]});
    end
  endgenerate

  // Pixel index is row*3+col: right minus left column for Gx, bottom minus top row for Gy.
  assign w_gx = (w_p[2] + (w_p[5] <<< 1) + w_p[8]) - (w_p[0] + (w_p[3] <<< 1) + w_p[6]);
  assign w_gy = (w_p[6] + (w_p[7] <<< 1) + w_p[8]) - (w_p[0] + (w_p[1] <<< 1) + w_p[2]);
  assign w_ax = A_W'(w_gx[G_W-1] ? -w_gx : w_gx);
  assign w_ay = A_W'(w_gy[G_W-1] ? -w_gy : w_gy);

  assign w_ax_ext = {{(S_W-A_W){1'b0}}, r_ax};
  assign w_ay_ext = {{(S_W-A_W){1'b0}}, r_ay};
  assign w_sq     = w_ax_ext * w_ax_ext + w_ay_ext * w_ay_ext;

  // Restoring square root: pull in two radicand bits, try subtracting 4*root+1.
  assign w_rem_sh = {r_rem, r_rad[R_W-1 -: 2]};
  assign w_trial  = {1'b0, r_root, 2'b01};
  assign w_fit    = (w_rem_sh >= w_trial);
  assign w_rem_nx = w_fit ? REM_W'(w_rem_sh - w_trial) : REM_W'(w_rem_sh);

  assign w_mag   = r_mode ? r_root : MAG_W'({1'b0, r_ax} + {1'b0, r_ay});
  assign w_class = (w_mag >= r_hi) ? 2'd2 : ((w_mag >= r_lo) ? 2'd1 : 2'd0);
  assign w_pix   = (w_class == 2'd2) ? 8'd255 : ((w_class == 2'd1) ? 8'd128 : 8'd0);

  always_ff @(posedge Clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_win       <= '0;
      r_mode      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_ax        <= '0;
      r_ay        <= '0;
      r_rad       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_cnt       <= '0;
      r_gm        <= '0;
      r_class     <= 2'd0;
      r_pix       <= 8'd0;
      r_out_valid <= 1'b0;
      r_strong    <= '0;
      r_weak      <= '0;
    end else if (Enable) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_win   <= bus.A;
            r_mode  <= bus.mode;
            r_hi    <= bus.hi_thr;
            r_lo    <= bus.lo_thr;
            r_state <= ST_GRAD;
          end
        end
        ST_GRAD: begin
          r_ax    <= w_ax;
          r_ay    <= w_ay;
          r_state <= r_mode ? ST_SQ : ST_CLASS;
        end
        ST_SQ: begin
          r_rad   <= {{(R_W-S_W){1'b0}}, w_sq};
          r_rem   <= '0;
          r_root  <= '0;
          r_cnt   <= IT_W'(MAG_W - 1);
          r_state <= ST_ROOT;
        end
        ST_ROOT: begin
          r_rem  <= w_rem_nx;
          r_root <= {r_root[MAG_W-2:0], w_fit};
          r_rad  <= {r_rad[R_W-3:0], 2'b00};
          if (r_cnt == '0) r_state <= ST_CLASS;
          else             r_cnt   <= r_cnt - IT_W'(1);
        end
        ST_CLASS: begin
          r_gm        <= w_mag;
          r_class     <= w_class;
          r_pix       <= w_pix;
          r_out_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
            if (r_class == 2'd2 && r_strong != '1) r_strong <= r_strong + CNT_W'(1);
            if (r_class == 2'd1 && r_weak != '1)   r_weak   <= r_weak + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == ST_IDLE) && Enable;
  assign bus.out_valid  = r_out_valid;
  assign bus.GM         = r_gm;
  assign bus.edge_class = r_class;
  assign bus.edge_pix   = r_pix;
  assign bus.strong_cnt = r_strong;
  assign bus.weak_cnt   = r_weak;
endmodule

// File: tb/tb_sobel_mag_core.sv
`timescale 1ns/1ps
// Directed plus random bench for sobel_mag_core with a behavioural magnitude
// model feeding an expected-result queue.
module tb_sobel_mag_core;
  localparam int DW = 8;
  localparam int MW = DW + 3;
  localparam int CW = 16;
  localparam int LAT_L1 = 3;
  localparam int LAT_L2 = 4 + MW;

  logic Clock = 1'b0;
  logic reset;
  logic Enable;

  sobel_mag_core_if #(.DATA_W(DW), .MAG_W(MW), .CNT_W(CW)) bus();

  sobel_mag_core #(.DATA_W(DW), .MAG_W(MW), .CNT_W(CW)) dut (
    .Clock  (Clock),
    .reset  (reset),
    .Enable (Enable),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int gm;
    int cls;
    int pix;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;
  int   mdl_strong = 0;
  int   mdl_weak = 0;
  int   ntx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [9*DW-1:0] win9(input int p00, input int p01, input int p02,
                                           input int p10, input int p11, input int p12,
                                           input int p20, input int p21, input int p22);
    logic [9*DW-1:0] w;
    w[0*DW +: DW] = DW'(p00); w[1*DW +: DW] = DW'(p01); w[2*DW +: DW] = DW'(p02);
    w[3*DW +: DW] = DW'(p10); w[4*DW +: DW] = DW'(p11); w[5*DW +: DW] = DW'(p12);
    w[6*DW +: DW] = DW'(p20); w[7*DW +: DW] = DW'(p21); w[8*DW +: DW] = DW'(p22);
    return w;
  endfunction

  function automatic exp_t model(input logic [9*DW-1:0] win, input bit md, input int hi, input int lo);
    int p[9];
    int gx, gy, ax, ay, s, r;
    exp_t e;
    for (int i = 0; i < 9; i++) p[i] = int'(win[i*DW +: DW]);
    gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    if (!md) begin
      e.gm = ax + ay;
    end else begin
      s = ax*ax + ay*ay;
      r = 0;
      while ((r+1)*(r+1) <= s) r++;
      e.gm = r;
    end
    e.cls = (e.gm >= hi) ? 2 : ((e.gm >= lo) ? 1 : 0);
    e.pix = (e.cls == 2) ? 255 : ((e.cls == 1) ? 128 : 0);
    return e;
  endfunction

  // Returns just after the accept edge.
  task automatic send(input logic [9*DW-1:0] win, input bit md, input int hi, input int lo);
    int n;
    sb.push_back(model(win, md, hi, lo));
    @(negedge Clock);
    bus.A        = win;
    bus.mode     = md;
    bus.hi_thr   = MW'(hi);
    bus.lo_thr   = MW'(lo);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge Clock);
      n++;
    end
    check("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    @(posedge Clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts the accept edge as 1; optionally drops Enable for frz_len edges once lat==frz_at.
  task automatic wait_out(input string tag, input int exp_lat, input int frz_at, input int frz_len);
    int lat;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      if (lat == frz_at) begin
        Enable = 1'b0;
        repeat (frz_len) begin
          @(posedge Clock);
          #1;
          lat++;
        end
        check({tag, "_frz_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_frz_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        Enable = 1'b1;
      end else begin
        @(posedge Clock);
        #1;
        lat++;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    last_exp = sb.pop_front();
    check({tag, "_gm"}, {21'd0, bus.GM}, last_exp.gm);
    check({tag, "_class"}, {30'd0, bus.edge_class}, last_exp.cls);
    check({tag, "_pix"}, {24'd0, bus.edge_pix}, last_exp.pix);
    check({tag, "_in_ready_busy"}, {31'd0, bus.in_ready}, 32'd0);
  endtask

  task automatic handshake(input string tag);
    @(negedge Clock);
    bus.out_ready = 1'b1;
    @(posedge Clock);
    #1;
    bus.out_ready = 1'b0;
    if (last_exp.cls == 2) mdl_strong++;
    else if (last_exp.cls == 1) mdl_weak++;
    check({tag, "_ov_clear"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_in_ready_idle"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_strong_cnt"}, {16'd0, bus.strong_cnt}, mdl_strong);
    check({tag, "_weak_cnt"}, {16'd0, bus.weak_cnt}, mdl_weak);
    ntx++;
    $display("tx %0d %s: GM=%0d class=%0d pix=%0d strong=%0d weak=%0d",
             ntx, tag, bus.GM, bus.edge_class, bus.edge_pix, bus.strong_cnt, bus.weak_cnt);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9*DW-1:0] w_vert, w_mirr, w_p22, w_zero, w_rnd;
    bit md;
    int hi, lo;

    w_zero = '0;
    w_vert = win9(0, 128, 255, 0, 128, 255, 0, 128, 255);
    w_mirr = win9(255, 128, 0, 255, 128, 0, 255, 128, 0);
    w_p22  = win9(0, 0, 0, 0, 0, 0, 0, 0, 255);

    reset = 1'b1;
    Enable = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.mode = 1'b0;
    bus.hi_thr = '0;
    bus.lo_thr = '0;

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check("rst_in_ready_en0", {31'd0, bus.in_ready}, 32'd0);
    Enable = 1'b1;
    #1;
    check("rst_in_ready_en1", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_gm", {21'd0, bus.GM}, 32'd0);
    check("rst_class", {30'd0, bus.edge_class}, 32'd0);
    check("rst_pix", {24'd0, bus.edge_pix}, 32'd0);
    check("rst_strong", {16'd0, bus.strong_cnt}, 32'd0);
    check("rst_weak", {16'd0, bus.weak_cnt}, 32'd0);
    @(negedge Clock);
    reset = 1'b0;

    // All-zero window, L1
    send(w_zero, 1'b0, 500, 100);
    wait_out("zero_l1", LAT_L1, -1, 0);
    check("zero_l1_gm_const", {21'd0, bus.GM}, 32'd0);
    handshake("zero_l1");

    // Vertical edge, L2
    send(w_vert, 1'b1, 500, 100);
    wait_out("vert_l2", LAT_L2, -1, 0);
    check("vert_l2_gm_const", {21'd0, bus.GM}, 32'd1020);
    check("vert_l2_pix_const", {24'd0, bus.edge_pix}, 32'd255);
    handshake("vert_l2");
    check("vert_l2_strong_const", {16'd0, bus.strong_cnt}, 32'd1);

    // Single corner pixel in both modes
    send(w_p22, 1'b0, 400, 300);
    wait_out("p22_l1", LAT_L1, -1, 0);
    check("p22_l1_gm_const", {21'd0, bus.GM}, 32'd510);
    handshake("p22_l1");
    send(w_p22, 1'b1, 400, 300);
    wait_out("p22_l2", LAT_L2, -1, 0);
    check("p22_l2_gm_const", {21'd0, bus.GM}, 32'd360);
    check("p22_l2_pix_const", {24'd0, bus.edge_pix}, 32'd128);
    handshake("p22_l2");

    // Mirrored edge: negative Gx
    send(w_mirr, 1'b1, 500, 100);
    wait_out("mirr_l2", LAT_L2, -1, 0);
    check("mirr_l2_gm_const", {21'd0, bus.GM}, 32'd1020);
    handshake("mirr_l2");

    // Threshold boundaries, including lo above hi
    send(w_p22, 1'b0, 510, 0);
    wait_out("thr_eq_hi", LAT_L1, -1, 0);
    handshake("thr_eq_hi");
    send(w_p22, 1'b0, 511, 510);
    wait_out("thr_eq_lo", LAT_L1, -1, 0);
    handshake("thr_eq_lo");
    send(w_p22, 1'b0, 100, 2000);
    wait_out("thr_lo_gt_hi", LAT_L1, -1, 0);
    check("thr_lo_gt_hi_class_const", {30'd0, bus.edge_class}, 32'd2);
    handshake("thr_lo_gt_hi");
    send(w_p22, 1'b0, 2047, 511);
    wait_out("thr_none", LAT_L1, -1, 0);
    handshake("thr_none");

    // Backpressure, then out_ready during a freeze must be ignored
    send(w_vert, 1'b0, 500, 100);
    wait_out("bp", LAT_L1, -1, 0);
    repeat (10) begin
      @(posedge Clock);
      #1;
    end
    check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp_gm", {21'd0, bus.GM}, last_exp.gm);
    check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    Enable = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) begin
      @(posedge Clock);
      #1;
    end
    check("frz_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("frz_strong", {16'd0, bus.strong_cnt}, mdl_strong);
    check("frz_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b0;
    Enable = 1'b1;
    handshake("bp");

    // Enable dropped for 5 cycles during ROOT
    send(w_p22, 1'b1, 400, 300);
    wait_out("frz_root", LAT_L2 + 5, 6, 5);
    handshake("frz_root");

    // Reset during ROOT aborts the result
    send(w_vert, 1'b1, 500, 100);
    repeat (6) begin
      @(posedge Clock);
      #1;
    end
    reset = 1'b1;
    @(posedge Clock);
    #1;
    reset = 1'b0;
    void'(sb.pop_back());
    mdl_strong = 0;
    mdl_weak = 0;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_gm", {21'd0, bus.GM}, 32'd0);
    check("midrst_strong", {16'd0, bus.strong_cnt}, 32'd0);
    check("midrst_weak", {16'd0, bus.weak_cnt}, 32'd0);
    send(w_vert, 1'b1, 500, 100);
    wait_out("post_rst", LAT_L2, -1, 0);
    check("post_rst_gm_const", {21'd0, bus.GM}, 32'd1020);
    handshake("post_rst");

    // Random windows and thresholds
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 9; i++) w_rnd[i*DW +: DW] = DW'($urandom_range(0, 255));
      md = 1'($urandom_range(0, 1));
      hi = $urandom_range(0, 1500);
      lo = $urandom_range(0, 1500);
      send(w_rnd, md, hi, lo);
      wait_out("rnd", md ? LAT_L2 : LAT_L1, -1, 0);
      handshake("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
